mmul_parallel_ctrl_fsm: RTL and testbench

- Sequencing controller for the mmul_parallel HWPE engine.
- Sits between the HWPE register file/slave controller and the engine plus streamer.
- Runs NB_ITER iterations, each of LEN_ITER elements.
- Per iteration: pulses the in1/in2/out_r streamer requests with per-iteration base addresses, starts and enables the engine, and waits for engine and output-sink completion.
- Raises a one-cycle done event after the last iteration.

---
 rtl/mmul_parallel_ctrl_fsm_pkg.sv | 47 ++++
 rtl/mmul_parallel_ctrl_fsm_addr_gen.sv | 48 ++++
 rtl/mmul_parallel_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_mmul_parallel_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_parallel_ctrl_fsm_pkg.sv
// Shared types and constants for the mmul_parallel sequencing controller.
package mmul_parallel_package;

   localparam int unsigned MMUL_PARALLEL_CNT_LEN   = 1024;
   localparam int unsigned MMUL_PARALLEL_LEN_W     = $clog2(MMUL_PARALLEL_CNT_LEN) + 1;
   localparam int unsigned MMUL_PARALLEL_NB_ITER_W = 16;
   localparam int unsigned MMUL_PARALLEL_ADDR_W    = 32;

   typedef logic [2:0] state_fsm_t;

   localparam state_fsm_t FSM_IDLE      = 3'd0;
   localparam state_fsm_t FSM_START     = 3'd1;
   localparam state_fsm_t FSM_COMPUTE   = 3'd2;
   localparam state_fsm_t FSM_WAIT      = 3'd3;
   localparam state_fsm_t FSM_UPDATEIDX = 3'd4;
   localparam state_fsm_t FSM_TERMINATE = 3'd5;

   typedef struct packed {
      logic [MMUL_PARALLEL_NB_ITER_W-1:0] nb_iter;
      logic [MMUL_PARALLEL_LEN_W-1:0]     len;
      logic [4:0]                         shift;
      logic                               simple_mul;
      logic [MMUL_PARALLEL_ADDR_W-1:0]    stride;
      logic [MMUL_PARALLEL_ADDR_W-1:0]    in1_base;
      logic [MMUL_PARALLEL_ADDR_W-1:0]    in2_base;
      logic [MMUL_PARALLEL_ADDR_W-1:0]    out_r_base;
   } ctrl_fsm_cfg_t;

   typedef struct packed {
      logic clear;
      logic enable;
      logic start;
   } ctrl_engine_t;

   typedef struct packed {
      logic eng_done;
      logic out_done;
      logic streams_ready;
   } flags_engine_t;

   typedef struct packed {
      logic streams_req;
      logic done;
      logic busy;
   } ctrl_fsm_t;

endpackage

// File: rtl/mmul_parallel_ctrl_fsm_addr_gen.sv
// Per-iteration base address registers for the in1/in2/out_r streamers:
// loaded from the job bases, advanced by the stride once per iteration.
module mmul_parallel_addr_gen #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [ADDR_W-1:0] stride_i,
   input  logic [ADDR_W-1:0] in1_base_i,
   input  logic [ADDR_W-1:0] in2_base_i,
   input  logic [ADDR_W-1:0] out_r_base_i,
   output logic [ADDR_W-1:0] in1_addr_o,
   output logic [ADDR_W-1:0] in2_addr_o,
   output logic [ADDR_W-1:0] out_r_addr_o
);

   logic [ADDR_W-1:0] in1_q, in2_q, out_r_q;

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in1_q   <= '0;
         in2_q   <= '0;
         out_r_q <= '0;
      end else if (clear_i) begin
         in1_q   <= '0;
         in2_q   <= '0;
         out_r_q <= '0;
      end else if (load_i) begin
         in1_q   <= in1_base_i;
         in2_q   <= in2_base_i;
         out_r_q <= out_r_base_i;
      end else if (advance_i) begin
         // Addresses wrap modulo 2^ADDR_W by construction.
         in1_q   <= in1_q + stride_i;
         in2_q   <= in2_q + stride_i;
         out_r_q <= out_r_q + stride_i;
      end
   end

   assign in1_addr_o   = in1_q;
   assign in2_addr_o   = in2_q;
   assign out_r_addr_o = out_r_q;

endmodule

// File: rtl/mmul_parallel_ctrl_fsm.sv
// Sequencing controller for the mmul_parallel engine: runs nb_iter iterations of
// streamer requests plus engine compute. Optional busy counter: MMUL_PARALLEL_PERF_CNT_EN.
module mmul_parallel_ctrl_fsm
   import mmul_parallel_package::*;
#(
   parameter int unsigned CNT_LEN   = MMUL_PARALLEL_CNT_LEN,
   parameter int unsigned NB_ITER_W = MMUL_PARALLEL_NB_ITER_W,
   parameter int unsigned ADDR_W    = MMUL_PARALLEL_ADDR_W,
   localparam int unsigned LEN_W    = $clog2(CNT_LEN) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [NB_ITER_W-1:0] nb_iter_i,
   input  logic [LEN_W-1:0]     len_iter_i,
   input  logic [4:0]           shift_i,
   input  logic                 simple_mul_i,
   input  logic [ADDR_W-1:0]    stride_i,
   input  logic [ADDR_W-1:0]    in1_base_i,
   input  logic [ADDR_W-1:0]    in2_base_i,
   input  logic [ADDR_W-1:0]    out_r_base_i,
   input  logic                 in1_ready_i,
   input  logic                 in2_ready_i,
   input  logic                 out_r_ready_i,
   input  logic                 out_r_done_i,
   input  logic                 eng_done_i,
   output logic                 in1_req_o,
   output logic                 in2_req_o,
   output logic                 out_r_req_o,
   output logic [ADDR_W-1:0]    in1_addr_o,
   output logic [ADDR_W-1:0]    in2_addr_o,
   output logic [ADDR_W-1:0]    out_r_addr_o,
   output logic                 eng_clear_o,
   output logic                 eng_enable_o,
   output logic                 eng_start_o,
   output logic [LEN_W-1:0]     eng_len_o,
   output logic [4:0]           eng_shift_o,
   output logic                 eng_simple_mul_o,
   output logic [NB_ITER_W-1:0] iter_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [31:0]          busy_cycles_o
);

   state_fsm_t           state_q, state_d;
   logic                 start_pend_q, start_pend_d;
   logic                 out_done_q, out_done_d;
   logic                 upd_hold_q, upd_hold_d;
   logic                 clear_q;
   logic [NB_ITER_W-1:0] iter_q, iter_d;
   logic [NB_ITER_W-1:0] nb_iter_q;
   logic [LEN_W-1:0]     len_q;
   logic [4:0]           shift_q;
   logic                 simple_mul_q;
   logic [ADDR_W-1:0]    stride_q;
   logic                 cfg_load, addr_advance;

   ctrl_fsm_cfg_t cfg_d;
   flags_engine_t flags;
   ctrl_engine_t  eng_ctrl;
   ctrl_fsm_t     fsm_ctrl;

   always_comb begin
      cfg_d            = '0;
      cfg_d.nb_iter    = MMUL_PARALLEL_NB_ITER_W'(nb_iter_i);
      cfg_d.len        = MMUL_PARALLEL_LEN_W'(len_iter_i);
      cfg_d.shift      = shift_i;
      cfg_d.simple_mul = simple_mul_i;
      cfg_d.stride     = MMUL_PARALLEL_ADDR_W'(stride_i);
      cfg_d.in1_base   = MMUL_PARALLEL_ADDR_W'(in1_base_i);
      cfg_d.in2_base   = MMUL_PARALLEL_ADDR_W'(in2_base_i);
      cfg_d.out_r_base = MMUL_PARALLEL_ADDR_W'(out_r_base_i);
   end

   assign flags = '{eng_done:      eng_done_i,
                    out_done:      out_r_done_i,
                    streams_ready: in1_ready_i & in2_ready_i & out_r_ready_i};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      start_pend_d = start_pend_q;
      out_done_d   = out_done_q;
      upd_hold_d   = upd_hold_q;
      iter_d       = iter_q;
      cfg_load     = 1'b0;
      addr_advance = 1'b0;
      case (state_q)
         FSM_IDLE: begin
            if (start_i) begin
               cfg_load     = 1'b1;
               iter_d       = '0;
               start_pend_d = 1'b0;
               if (NB_ITER_W'(cfg_d.nb_iter) == '0) state_d = FSM_TERMINATE;
               else if (flags.streams_ready)         state_d = FSM_START;
               else                                  start_pend_d = 1'b1;
            end else if (start_pend_q && flags.streams_ready) begin
               start_pend_d = 1'b0;
               state_d      = FSM_START;
            end
         end
         FSM_START: begin
            out_done_d = 1'b0;
            state_d    = FSM_COMPUTE;
         end
         FSM_COMPUTE: begin
            if (flags.out_done) out_done_d = 1'b1;
            if (flags.eng_done)
               state_d = (out_done_q || flags.out_done) ? FSM_UPDATEIDX : FSM_WAIT;
         end
         FSM_WAIT: begin
            if (flags.out_done) state_d = FSM_UPDATEIDX;
         end
         FSM_UPDATEIDX: begin
            // The hold flag keeps a stalled UPDATEIDX from advancing twice.
            if (!upd_hold_q) begin
               if (iter_q + NB_ITER_W'(1) == nb_iter_q) begin
                  state_d = FSM_TERMINATE;
               end else begin
                  iter_d       = iter_q + NB_ITER_W'(1);
                  addr_advance = 1'b1;
                  if (flags.streams_ready) state_d    = FSM_START;
                  else                     upd_hold_d = 1'b1;
               end
            end else if (flags.streams_ready) begin
               upd_hold_d = 1'b0;
               state_d    = FSM_START;
            end
         end
         FSM_TERMINATE: state_d = FSM_IDLE;
         default:       state_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FSM_IDLE;
         start_pend_q <= 1'b0;
         out_done_q   <= 1'b0;
         upd_hold_q   <= 1'b0;
         iter_q       <= '0;
         clear_q      <= 1'b0;
         nb_iter_q    <= '0;
         len_q        <= '0;
         shift_q      <= '0;
         simple_mul_q <= 1'b0;
         stride_q     <= '0;
      end else begin
         clear_q <= clear_i;
         if (clear_i) begin
            state_q      <= FSM_IDLE;
            start_pend_q <= 1'b0;
            out_done_q   <= 1'b0;
            upd_hold_q   <= 1'b0;
            iter_q       <= '0;
         end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            out_done_q   <= out_done_d;
            upd_hold_q   <= upd_hold_d;
            iter_q       <= iter_d;
            if (cfg_load) begin
               nb_iter_q    <= NB_ITER_W'(cfg_d.nb_iter);
               len_q        <= LEN_W'(cfg_d.len);
               shift_q      <= cfg_d.shift;
               simple_mul_q <= cfg_d.simple_mul;
               stride_q     <= ADDR_W'(cfg_d.stride);
            end
         end
      end
   end

   mmul_parallel_addr_gen #(
      .ADDR_W (ADDR_W)
   ) i_addr_gen (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .load_i       (cfg_load),
      .advance_i    (addr_advance),
      .stride_i     (stride_q),
      .in1_base_i   (ADDR_W'(cfg_d.in1_base)),
      .in2_base_i   (ADDR_W'(cfg_d.in2_base)),
      .out_r_base_i (ADDR_W'(cfg_d.out_r_base)),
      .in1_addr_o   (in1_addr_o),
      .in2_addr_o   (in2_addr_o),
      .out_r_addr_o (out_r_addr_o)
   );

   assign eng_ctrl = '{clear:  clear_q,
                       enable: (state_q == FSM_COMPUTE) || (state_q == FSM_WAIT),
                       start:  (state_q == FSM_START)};

   assign fsm_ctrl = '{streams_req: (state_q == FSM_START),
                       done:        (state_q == FSM_TERMINATE),
                       busy:        (state_q != FSM_IDLE)};

   assign in1_req_o        = fsm_ctrl.streams_req;
   assign in2_req_o        = fsm_ctrl.streams_req;
   assign out_r_req_o      = fsm_ctrl.streams_req;
   assign eng_clear_o      = eng_ctrl.clear;
   assign eng_enable_o     = eng_ctrl.enable;
   assign eng_start_o      = eng_ctrl.start;
   assign eng_len_o        = len_q;
   assign eng_shift_o      = shift_q;
   assign eng_simple_mul_o = simple_mul_q;
   assign iter_o           = iter_q;
   assign busy_o           = fsm_ctrl.busy;
   assign done_o           = fsm_ctrl.done;

`ifdef MMUL_PARALLEL_PERF_CNT_EN
   logic [31:0] busy_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_cnt_q <= '0;
      end else if (clear_i || (state_q == FSM_IDLE && start_i)) begin
         busy_cnt_q <= '0;
      end else if (busy_o && (busy_cnt_q != '1)) begin
         busy_cnt_q <= busy_cnt_q + 32'd1;
      end
   end

   assign busy_cycles_o = busy_cnt_q;
`else
   assign busy_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mmul_parallel_ctrl_fsm.sv
// Directed bench for mmul_parallel_ctrl_fsm; expected streamer addresses are queued
// when a job is launched and popped on each observed request pulse.
module tb_mmul_parallel_ctrl_fsm;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i, start_i;
   logic [15:0] nb_iter_i;
   logic [10:0] len_iter_i;
   logic [4:0]  shift_i;
   logic        simple_mul_i;
   logic [31:0] stride_i, in1_base_i, in2_base_i, out_r_base_i;
   logic        in1_ready_i, in2_ready_i, out_r_ready_i;
   logic        out_r_done_i, eng_done_i;
   logic        in1_req_o, in2_req_o, out_r_req_o;
   logic [31:0] in1_addr_o, in2_addr_o, out_r_addr_o;
   logic        eng_clear_o, eng_enable_o, eng_start_o;
   logic [10:0] eng_len_o;
   logic [4:0]  eng_shift_o;
   logic        eng_simple_mul_o;
   logic [15:0] iter_o;
   logic        busy_o, done_o;
   logic [31:0] busy_cycles_o;

   typedef struct {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [31:0] out_r;
      logic [15:0] iter;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   req_cnt = 0, eng_start_cnt = 0, done_cnt = 0, busy_seen = 0;

   always #5 clk_i = ~clk_i;

   mmul_parallel_ctrl_fsm dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .nb_iter_i(nb_iter_i), .len_iter_i(len_iter_i), .shift_i(shift_i),
      .simple_mul_i(simple_mul_i), .stride_i(stride_i),
      .in1_base_i(in1_base_i), .in2_base_i(in2_base_i), .out_r_base_i(out_r_base_i),
      .in1_ready_i(in1_ready_i), .in2_ready_i(in2_ready_i), .out_r_ready_i(out_r_ready_i),
      .out_r_done_i(out_r_done_i), .eng_done_i(eng_done_i),
      .in1_req_o(in1_req_o), .in2_req_o(in2_req_o), .out_r_req_o(out_r_req_o),
      .in1_addr_o(in1_addr_o), .in2_addr_o(in2_addr_o), .out_r_addr_o(out_r_addr_o),
      .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .eng_start_o(eng_start_o),
      .eng_len_o(eng_len_o), .eng_shift_o(eng_shift_o), .eng_simple_mul_o(eng_simple_mul_o),
      .iter_o(iter_o), .busy_o(busy_o), .done_o(done_o), .busy_cycles_o(busy_cycles_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_job(input int n, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3, input logic [31:0] s);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.in1   = b1 + 32'(k) * s;
         e.in2   = b2 + 32'(k) * s;
         e.out_r = b3 + 32'(k) * s;
         e.iter  = 16'(k);
         sb.push_back(e);
      end
   endtask

   // One clock: sample #1 after the edge and score any request pulse.
   task automatic tick();
      @(posedge clk_i);
      #1;
      if (done_o) done_cnt++;
      if (busy_o) busy_seen++;
      if (eng_start_o) eng_start_cnt++;
      if (in1_req_o) begin
         req_cnt++;
         check("in2_req", 32'(in2_req_o), 32'd1);
         check("out_r_req", 32'(out_r_req_o), 32'd1);
         check("eng_start", 32'(eng_start_o), 32'd1);
         if (sb.size() == 0) begin
            check("unexpected_req_iter", 32'(iter_o), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("in1_addr", in1_addr_o, e.in1);
            check("in2_addr", in2_addr_o, e.in2);
            check("out_r_addr", out_r_addr_o, e.out_r);
            check("req_iter", 32'(iter_o), 32'(e.iter));
         end
      end
   endtask

   task automatic wait_req(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (in1_req_o) return;
      end
      check("wait_req_timeout", 32'(in1_req_o), 32'd1);
   endtask

   task automatic launch(input logic [15:0] nb, input logic [10:0] len, input logic [4:0] sh,
                         input logic sm, input logic [31:0] s, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
      nb_iter_i = nb; len_iter_i = len; shift_i = sh; simple_mul_i = sm;
      stride_i = s; in1_base_i = b1; in2_base_i = b2; out_r_base_i = b3;
      busy_seen = 0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Called in a START cycle; out_r_done/eng_done arrive on the given COMPUTE cycle.
   task automatic do_iter(input int eng_lat, input int out_lat);
      int n;
      n = (eng_lat > out_lat) ? eng_lat : out_lat;
      tick();
      check("enable_compute", 32'(eng_enable_o), 32'd1);
      for (int k = 1; k <= n; k++) begin
         eng_done_i   = (k == eng_lat);
         out_r_done_i = (k == out_lat);
         tick();
         if (k == eng_lat)
            check("enable_after_eng_done", 32'(eng_enable_o), (out_lat <= eng_lat) ? 32'd0 : 32'd1);
      end
      eng_done_i   = 1'b0;
      out_r_done_i = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, r0, s0;
      rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
      nb_iter_i = '0; len_iter_i = '0; shift_i = '0; simple_mul_i = 1'b0;
      stride_i = '0; in1_base_i = '0; in2_base_i = '0; out_r_base_i = '0;
      in1_ready_i = 1'b1; in2_ready_i = 1'b1; out_r_ready_i = 1'b1;
      out_r_done_i = 1'b0; eng_done_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_iter", 32'(iter_o), 32'd0);
      check("rst_in1_addr", in1_addr_o, 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_req", 32'(in1_req_o), 32'd0);
      check("rst_eng_clear", 32'(eng_clear_o), 32'd0);
      check("rst_busy_cycles", busy_cycles_o, 32'd0);
      rst_ni = 1'b1;
      tick();

      // Three iterations: plain, WAIT path, sticky out-done path.
      push_job(3, 32'h1000, 32'h2000, 32'h3000, 32'h40);
      launch(16'd3, 11'd16, 5'd7, 1'b1, 32'h40, 32'h1000, 32'h2000, 32'h3000);
      check("t1_first_req", 32'(req_cnt), 32'd1);
      check("t1_len", 32'(eng_len_o), 32'd16);
      check("t1_shift", 32'(eng_shift_o), 32'd7);
      check("t1_simple_mul", 32'(eng_simple_mul_o), 32'd1);
      do_iter(4, 4);
      wait_req(4);
      do_iter(2, 5);
      wait_req(4);
      do_iter(5, 2);
      check("t1_iter_final", 32'(iter_o), 32'd2);
      tick();
      check("t1_done", 32'(done_o), 32'd1);
      tick();
      check("t1_done_clr", 32'(done_o), 32'd0);
      check("t1_idle", 32'(busy_o), 32'd0);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_req_cnt", 32'(req_cnt), 32'd3);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);
`ifdef MMUL_PARALLEL_PERF_CNT_EN
      check("t1_busy_cycles", busy_cycles_o, 32'(busy_seen));
`else
      check("t1_busy_cycles", busy_cycles_o, 32'd0);
`endif

      // Zero iterations: straight to TERMINATE without any requests.
      d0 = done_cnt; r0 = req_cnt; s0 = eng_start_cnt;
      launch(16'd0, 11'd8, 5'd1, 1'b0, 32'h10, 32'h500, 32'h600, 32'h700);
      check("t2_done", 32'(done_o), 32'd1);
      tick();
      check("t2_done_clr", 32'(done_o), 32'd0);
      check("t2_idle", 32'(busy_o), 32'd0);
      check("t2_no_req", 32'(req_cnt - r0), 32'd0);
      check("t2_no_eng_start", 32'(eng_start_cnt - s0), 32'd0);
      check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Start held pending while in2 is not ready.
      push_job(1, 32'hA000, 32'hB000, 32'hC000, 32'h4);
      in2_ready_i = 1'b0;
      r0 = req_cnt;
      launch(16'd1, 11'd5, 5'd3, 1'b0, 32'h4, 32'hA000, 32'hB000, 32'hC000);
      check("t3_pending_idle", 32'(busy_o), 32'd0);
      repeat (4) tick();
      check("t3_no_req", 32'(req_cnt - r0), 32'd0);
      check("t3_still_idle", 32'(busy_o), 32'd0);
      in2_ready_i = 1'b1;
      tick();
      check("t3_start_after_ready", 32'(in1_req_o), 32'd1);
      do_iter(2, 2);
      tick();
      check("t3_done", 32'(done_o), 32'd1);
      tick();

      // Clear while waiting on the output sink in iteration 1.
      push_job(2, 32'h4000, 32'h5000, 32'h6000, 32'h100);
      d0 = done_cnt;
      launch(16'd3, 11'd9, 5'd2, 1'b0, 32'h100, 32'h4000, 32'h5000, 32'h6000);
      do_iter(2, 2);
      wait_req(4);
      tick();
      eng_done_i = 1'b1;
      tick();
      eng_done_i = 1'b0;
      check("t4_wait_enable", 32'(eng_enable_o), 32'd1);
      tick();
      check("t4_wait_iter", 32'(iter_o), 32'd1);
      check("t4_wait_busy", 32'(busy_o), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("t4_clear_idle", 32'(busy_o), 32'd0);
      check("t4_clear_iter", 32'(iter_o), 32'd0);
      check("t4_clear_addr", in1_addr_o, 32'd0);
      check("t4_eng_clear", 32'(eng_clear_o), 32'd1);
      check("t4_clear_enable", 32'(eng_enable_o), 32'd0);
      tick();
      check("t4_eng_clear_drop", 32'(eng_clear_o), 32'd0);
      repeat (3) tick();
      check("t4_no_done", 32'(done_cnt - d0), 32'd0);
      check("t4_sb_empty", 32'(sb.size()), 32'd0);
      check("t4_busy_cycles_cleared", busy_cycles_o, 32'd0);

      // Address wrap at the top of the address space.
      push_job(2, 32'hFFFF_FFF0, 32'h0000_0100, 32'hFFFF_FFE8, 32'h20);
      launch(16'd2, 11'd1024, 5'd31, 1'b1, 32'h20, 32'hFFFF_FFF0, 32'h0000_0100, 32'hFFFF_FFE8);
      check("t5_len", 32'(eng_len_o), 32'd1024);
      do_iter(3, 1);
      wait_req(4);
      check("t5_wrap_in1", in1_addr_o, 32'h0000_0010);
      do_iter(1, 3);
      tick();
      check("t5_done", 32'(done_o), 32'd1);
      tick();
      tick();
`ifdef MMUL_PARALLEL_PERF_CNT_EN
      check("t5_busy_cycles", busy_cycles_o, 32'(busy_seen));
`else
      check("t5_busy_cycles", busy_cycles_o, 32'd0);
`endif
      check("t5_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
